// File: rtl/full_add_pkg.sv
// full_add_pkg -- shared constants for the full_add ripple-carry adder.
//   FULL_ADD_DEFAULT_WIDTH : operand width used when none is given
//   FULL_ADD_MAX_WIDTH     : widest operand the adder accepts
//   full_add_width_ok()    : true when a requested width lies in 1..MAX
package full_add_pkg;

  localparam int FULL_ADD_DEFAULT_WIDTH = 32'sd1;
  localparam int FULL_ADD_MAX_WIDTH     = 32'sd64;

  function automatic bit full_add_width_ok(input int width);
    return (width >= 32'sd1) && (width <= FULL_ADD_MAX_WIDTH);
  endfunction

endpackage

// File: rtl/full_add_cell.sv
// full_add_cell -- one-bit combinational full adder, the link of the ripple chain.
// Ports:
//   a, b : addend bits
//   ci   : carry into this bit
//   s    : sum bit
//   co   : carry out of this bit
module full_add_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  // Propagate term is shared by the sum and the carry equations.
  logic p_s;

  assign p_s = a ^ b;
  assign s   = p_s ^ ci;
  assign co  = (a & b) | (ci & p_s);

endmodule

// File: rtl/full_add.sv
// full_add -- WIDTH-bit ripple-carry adder: {cyout, sum} = a + b + cyin (unsigned).
// Parameters:
//   WIDTH   : operand width, 1..64
//   REG_OUT : 1 = outputs registered (1-cycle latency), 0 = combinational
// Ports:
//   clk   : rising-edge clock (unused when REG_OUT = 0)
//   rst_n : asynchronous active-low reset of the output registers
//   a, b  : addends
//   cyin  : carry into bit 0
//   sum   : sum bits
//   cyout : carry out of the MSB
module full_add
  import full_add_pkg::*;
#(
  parameter int WIDTH   = FULL_ADD_DEFAULT_WIDTH,
  parameter bit REG_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cyin,
  output logic [WIDTH-1:0] sum,
  output logic             cyout
);

  // Reject illegal widths while elaborating rather than building a broken chain.
  if (!full_add_width_ok(WIDTH)) begin : g_width_err
    $error("full_add: WIDTH=%0d outside legal range 1..%0d", WIDTH, FULL_ADD_MAX_WIDTH);
  end

  // carry_s[i] is the carry into bit i; carry_s[WIDTH] is the final carry-out.
  logic [WIDTH:0]   carry_s;
  logic [WIDTH-1:0] sum_s;

  assign carry_s[0] = cyin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_add_cell u_cell (
      .a  (a[i]),
      .b  (b[i]),
      .ci (carry_s[i]),
      .s  (sum_s[i]),
      .co (carry_s[i+1])
    );
  end

  if (REG_OUT) begin : g_reg_out
    logic [WIDTH-1:0] sum_d;
    logic [WIDTH-1:0] sum_q;
    logic             cyout_d;
    logic             cyout_q;

    // Next-state: capture the ripple result unconditionally every cycle.
    always_comb begin
      sum_d   = sum_s;
      cyout_d = carry_s[WIDTH];
    end

    // Output registers; reset clears them at once, dropping any in-flight result.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sum_q   <= {WIDTH{1'b0}};
        cyout_q <= 1'b0;
      end else begin
        sum_q   <= sum_d;
        cyout_q <= cyout_d;
      end
    end

    assign sum   = sum_q;
    assign cyout = cyout_q;
  end else begin : g_comb_out
    // Clock and reset have no role in the combinational variant.
    logic unused_clk_rst_s;
    assign unused_clk_rst_s = clk & rst_n;

    assign sum   = sum_s;
    assign cyout = carry_s[WIDTH];
  end

endmodule

// File: tb/tb_full_add.sv
// tb_full_add -- self-checking bench for full_add: registered and combinational
// 1-bit instances, registered 8-bit and 16-bit instances, with a scoreboard queue
// per registered instance holding the expected {cyout, sum}.
module tb_full_add;

  logic clk;
  logic rst_n;

  logic       a1r, b1r, ci1r, s1r, co1r;
  logic       a1c, b1c, ci1c, s1c, co1c;
  logic [7:0] a8, b8, s8;
  logic       ci8, co8;
  logic [15:0] a16, b16, s16;
  logic        ci16, co16;

  int errors = 0;
  int checks = 0;

  // Expected {cyout, sum} for WIDTH=1 indexed by {a, b, cyin}.
  logic [1:0] tbl [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

  logic [1:0]  q1  [$];
  logic [8:0]  q8  [$];
  logic [16:0] q16 [$];

  full_add #(.WIDTH(1), .REG_OUT(1'b1)) u_w1_reg (
    .clk(clk), .rst_n(rst_n), .a(a1r), .b(b1r), .cyin(ci1r), .sum(s1r), .cyout(co1r)
  );
  full_add #(.WIDTH(1), .REG_OUT(1'b0)) u_w1_comb (
    .clk(clk), .rst_n(rst_n), .a(a1c), .b(b1c), .cyin(ci1c), .sum(s1c), .cyout(co1c)
  );
  full_add #(.WIDTH(8), .REG_OUT(1'b1)) u_w8_reg (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .cyin(ci8), .sum(s8), .cyout(co8)
  );
  full_add #(.WIDTH(16), .REG_OUT(1'b1)) u_w16_reg (
    .clk(clk), .rst_n(rst_n), .a(a16), .b(b16), .cyin(ci16), .sum(s16), .cyout(co16)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [16:0] obs, input logic [16:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Wait one active edge, then compare every registered instance that has a pending result.
  task automatic tick();
    logic [1:0]  e1;
    logic [8:0]  e8;
    logic [16:0] e16;
    @(posedge clk);
    #1;
    if (q1.size() > 0) begin
      e1 = q1.pop_front();
      chk("w1_reg", 17'({co1r, s1r}), 17'(e1));
    end
    if (q8.size() > 0) begin
      e8 = q8.pop_front();
      chk("w8_reg", 17'({co8, s8}), 17'(e8));
    end
    if (q16.size() > 0) begin
      e16 = q16.pop_front();
      chk("w16_reg", {co16, s16}, e16);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_w1"}, 17'({co1r, s1r}), 17'd0);
    chk({tag, "_w8"}, 17'({co8, s8}), 17'd0);
    chk({tag, "_w16"}, {co16, s16}, 17'd0);
  endtask

  initial begin
    logic [2:0] v;
    clk   = 1'b0;
    rst_n = 1'b0;
    {a1r, b1r, ci1r} = 3'b000;
    {a1c, b1c, ci1c} = 3'b000;
    a8 = 8'h00;  b8 = 8'h00;  ci8 = 1'b0;
    a16 = 16'h0000; b16 = 16'h0000; ci16 = 1'b0;

    // Reset state, before and across clock edges.
    #1;
    chk_all_zero("reset_t1");
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_all_zero("reset_edges");
    rst_n = 1'b1;

    // WIDTH=1 registered: all 8 combinations, one per cycle.
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      {a1r, b1r, ci1r} = v;
      q1.push_back(tbl[i]);
      tick();
    end

    // WIDTH=1 combinational: all 8 combinations at 5-unit intervals.
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      {a1c, b1c, ci1c} = v;
      #1;
      chk("w1_comb", 17'({co1c, s1c}), 17'(tbl[i]));
      #4;
    end

    // WIDTH=8 carry across the full width and wrap-around.
    a8 = 8'hFF; b8 = 8'h01; ci8 = 1'b0;
    q8.push_back(9'h100);
    tick();
    a8 = 8'hFF; b8 = 8'hFF; ci8 = 1'b1;
    q8.push_back(9'h1FF);
    tick();
    a8 = 8'hFF; b8 = 8'h00; ci8 = 1'b1;
    q8.push_back(9'h100);
    tick();
    a8 = 8'h5A; b8 = 8'h25; ci8 = 1'b1;
    q8.push_back(9'h080);
    tick();

    // WIDTH=16 boundaries, then random vectors issued back-to-back.
    a16 = 16'hFFFF; b16 = 16'hFFFF; ci16 = 1'b1;
    q16.push_back(17'h1FFFF);
    tick();
    a16 = 16'hFFFF; b16 = 16'h0000; ci16 = 1'b1;
    q16.push_back(17'h10000);
    tick();
    for (int n = 0; n < 10000; n++) begin
      a16  = 16'($urandom());
      b16  = 16'($urandom());
      ci16 = 1'($urandom());
      q16.push_back({1'b0, a16} + {1'b0, b16} + {16'h0000, ci16});
      tick();
    end

    // Mid-stream reset with all-ones inputs on the 1-bit registered adder.
    {a1r, b1r, ci1r} = 3'b111;
    q1.push_back(2'b11);
    tick();
    q1.push_back(2'b11);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("reset_async");
    q1.delete();
    q8.delete();
    q16.delete();
    @(posedge clk);
    #1;
    chk_all_zero("reset_held");
    rst_n = 1'b1;
    q1.push_back(2'b11);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Guard against a hung run.
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
